// File: rtl/vga_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : vga_pkg
// Description : Shared 640x480@60 Hz timing constants, coordinate types and
//               a small window-decode helper for the VGA scan generator and
//               every draw block that consumes its coordinates.
// Revision    : 1.0 - initial release
// ============================================================================
package vga_pkg;

    // Coordinate and frame-counter widths
    localparam int unsigned COORD_W   = 10;
    localparam int unsigned FRAME_W   = 16;

    // Raw timing constants (system clock 100 MHz, pixel clock 25 MHz)
    localparam int unsigned CLK_DIV   = 4;
    localparam int unsigned H_VISIBLE = 640;
    localparam int unsigned H_FRONT   = 16;
    localparam int unsigned H_SYNC    = 96;
    localparam int unsigned H_BACK    = 48;
    localparam int unsigned V_VISIBLE = 480;
    localparam int unsigned V_FRONT   = 10;
    localparam int unsigned V_SYNC    = 2;
    localparam int unsigned V_BACK    = 33;

    // Derived timing
    localparam int unsigned H_TOTAL   = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int unsigned V_TOTAL   = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
    localparam int unsigned HS_START  = H_VISIBLE + H_FRONT;
    localparam int unsigned HS_END    = HS_START + H_SYNC;
    localparam int unsigned VS_START  = V_VISIBLE + V_FRONT;
    localparam int unsigned VS_END    = VS_START + V_SYNC;
    localparam int unsigned REF_LINE  = V_VISIBLE;

    typedef logic [COORD_W-1:0] coord_t;
    typedef logic [FRAME_W-1:0] frame_t;

    // True when lo <= pos < hi; compared at 32 bits so hi may equal 2**COORD_W
    function automatic logic in_window(coord_t pos, int unsigned lo, int unsigned hi);
        return (32'(pos) >= lo) && (32'(pos) < hi);
    endfunction

endpackage
`default_nettype wire

// File: rtl/vga_sync_gen_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : vga_sync_gen_if
// Description : Pixel-coordinate / sync bundle driven by the scan generator
//               and consumed by draw blocks and the VGA pin drivers.
// Revision    : 1.0 - initial release
// ============================================================================
interface vga_sync_gen_if;
    import vga_pkg::*;

    coord_t hc;
    coord_t vc;
    logic   pix_tick;
    logic   video_on;
    logic   hsync;
    logic   vsync;
    logic   ref_tick;
    frame_t frame_cnt;

    modport master (
        output hc, vc, pix_tick, video_on, hsync, vsync, ref_tick, frame_cnt
    );

    modport slave (
        input  hc, vc, pix_tick, video_on, hsync, vsync, ref_tick, frame_cnt
    );

endinterface
`default_nettype wire

// File: rtl/vga_pix_div.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : vga_pix_div
// Description : Pixel-enable divider. Counts system clocks 0..CLK_DIV-1 and
//               flags the advance edge when the count is at its last value.
//               With CLK_DIV=1 every edge is an advance edge.
// Revision    : 1.0 - initial release
// ============================================================================
module vga_pix_div #(
    parameter int unsigned CLK_DIV = 4
) (
    input  logic clk,
    input  logic rst_n,
    output logic adv
);

    // A 1-bit counter is kept for CLK_DIV=1; it simply stays at zero
    localparam int unsigned      DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    if ((CLK_DIV < 1) || (CLK_DIV > 16)) begin : g_bad_div
        $error("vga_pix_div: CLK_DIV must lie in 1..16");
    end

    logic [DIV_W-1:0] div_cnt_q;
    logic [DIV_W-1:0] div_cnt_d;

    assign adv = (div_cnt_q == DIV_LAST);

    // Next divider count: wrap to zero on the advance edge
    always_comb begin
        div_cnt_d = div_cnt_q + 1'b1;
        if (adv) begin
            div_cnt_d = '0;
        end
    end

    // Divider register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt_q <= '0;
        end else begin
            div_cnt_q <= div_cnt_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/vga_sync_gen.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : vga_sync_gen
// Description : VGA scan generator. Produces hc/vc coordinates, active-low
//               hsync/vsync, video_on, a per-pixel tick, a once-per-frame
//               ref_tick at the start of vertical blank and a frame counter.
//               Sync/video_on are decoded from the next coordinates so every
//               output changes on the same edge as hc/vc.
// Revision    : 1.0 - initial release
// ============================================================================
module vga_sync_gen
    import vga_pkg::*;
#(
    parameter int unsigned CLK_DIV   = vga_pkg::CLK_DIV,
    parameter int unsigned H_VISIBLE = vga_pkg::H_VISIBLE,
    parameter int unsigned H_FRONT   = vga_pkg::H_FRONT,
    parameter int unsigned H_SYNC    = vga_pkg::H_SYNC,
    parameter int unsigned H_BACK    = vga_pkg::H_BACK,
    parameter int unsigned V_VISIBLE = vga_pkg::V_VISIBLE,
    parameter int unsigned V_FRONT   = vga_pkg::V_FRONT,
    parameter int unsigned V_SYNC    = vga_pkg::V_SYNC,
    parameter int unsigned V_BACK    = vga_pkg::V_BACK,
    // Value frame_cnt takes in reset; nonzero only to preload near the wrap
    parameter frame_t      FRAME_RST = '0
) (
    input  logic           clk,
    input  logic           rst_n,
    vga_sync_gen_if.master vga
);

    localparam int unsigned H_TOTAL  = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int unsigned V_TOTAL  = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
    localparam int unsigned HS_START = H_VISIBLE + H_FRONT;
    localparam int unsigned HS_END   = HS_START + H_SYNC;
    localparam int unsigned VS_START = V_VISIBLE + V_FRONT;
    localparam int unsigned VS_END   = VS_START + V_SYNC;
    localparam int unsigned REF_LINE = V_VISIBLE;

    // Coordinates must fit COORD_W bits and the blanking line must exist
    if ((H_TOTAL > (2 ** COORD_W)) || (V_TOTAL > (2 ** COORD_W))) begin : g_bad_totals
        $error("vga_sync_gen: H_TOTAL and V_TOTAL must not exceed 1024");
    end
    if ((H_VISIBLE == 0) || (V_VISIBLE == 0) || (V_TOTAL <= V_VISIBLE)) begin : g_bad_visible
        $error("vga_sync_gen: visible area must be nonzero and followed by vertical blank");
    end

    logic   adv;
    logic   h_last;
    logic   v_last;

    coord_t hc_q,        hc_d;
    coord_t vc_q,        vc_d;
    logic   pix_tick_q,  pix_tick_d;
    logic   video_on_q,  video_on_d;
    logic   hsync_q,     hsync_d;
    logic   vsync_q,     vsync_d;
    logic   ref_tick_q,  ref_tick_d;
    frame_t frame_cnt_q, frame_cnt_d;

    vga_pix_div #(
        .CLK_DIV (CLK_DIV)
    ) u_pix_div (
        .clk   (clk),
        .rst_n (rst_n),
        .adv   (adv)
    );

    assign h_last = (32'(hc_q) == (H_TOTAL - 1));
    assign v_last = (32'(vc_q) == (V_TOTAL - 1));

    // Next scan position: step one pixel per advance edge, wrap line and frame
    always_comb begin
        hc_d = hc_q;
        vc_d = vc_q;
        if (adv) begin
            if (h_last) begin
                hc_d = '0;
                vc_d = v_last ? '0 : vc_q + 1'b1;
            end else begin
                hc_d = hc_q + 1'b1;
            end
        end
    end

    // Output decode from the next position so outputs align with hc/vc
    always_comb begin
        hsync_d     = !in_window(hc_d, HS_START, HS_END);
        vsync_d     = !in_window(vc_d, VS_START, VS_END);
        video_on_d  = (32'(hc_d) < H_VISIBLE) && (32'(vc_d) < V_VISIBLE);
        pix_tick_d  = adv;
        // Only an advance can move the scan onto (0, REF_LINE), so this is one clk wide
        ref_tick_d  = adv && (hc_d == '0) && (32'(vc_d) == REF_LINE);
        frame_cnt_d = frame_cnt_q;
        if (ref_tick_d) begin
            frame_cnt_d = frame_cnt_q + 1'b1;
        end
    end

    // Output and counter registers; reset state matches position (0,0)
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hc_q        <= '0;
            vc_q        <= '0;
            pix_tick_q  <= 1'b0;
            video_on_q  <= 1'b1;
            hsync_q     <= 1'b1;
            vsync_q     <= 1'b1;
            ref_tick_q  <= 1'b0;
            frame_cnt_q <= FRAME_RST;
        end else begin
            hc_q        <= hc_d;
            vc_q        <= vc_d;
            pix_tick_q  <= pix_tick_d;
            video_on_q  <= video_on_d;
            hsync_q     <= hsync_d;
            vsync_q     <= vsync_d;
            ref_tick_q  <= ref_tick_d;
            frame_cnt_q <= frame_cnt_d;
        end
    end

    assign vga.hc        = hc_q;
    assign vga.vc        = vc_q;
    assign vga.pix_tick  = pix_tick_q;
    assign vga.video_on  = video_on_q;
    assign vga.hsync     = hsync_q;
    assign vga.vsync     = vsync_q;
    assign vga.ref_tick  = ref_tick_q;
    assign vga.frame_cnt = frame_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_vga_sync_gen.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_vga_sync_gen
// Description : Self-checking bench for vga_sync_gen. Two reduced-timing
//               instances: A (CLK_DIV=4, 16x9 frame) and B (CLK_DIV=1, 7x6
//               frame, frame counter preloaded near its wrap). Expected values
//               come from hand-derived vectors and an arithmetic model that
//               maps clock edges since reset release to scan position.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_vga_sync_gen;
    import vga_pkg::*;

    localparam int A_CD = 4, A_HV = 8, A_HF = 2, A_HS = 3, A_HB = 3;
    localparam int A_VV = 4, A_VF = 1, A_VS = 2, A_VB = 2;
    localparam int B_CD = 1, B_HV = 4, B_HF = 1, B_HS = 1, B_HB = 1;
    localparam int B_VV = 3, B_VF = 1, B_VS = 1, B_VB = 1;
    localparam logic [15:0] B_FC0 = 16'hFFFD;

    typedef struct packed {
        logic [9:0]  hc;
        logic [9:0]  vc;
        logic        pix;
        logic        von;
        logic        hs;
        logic        vs;
        logic        rf;
        logic [15:0] fc;
    } obs_t;

    typedef struct {
        int   n_edge;
        obs_t exp;
    } vec_t;

    logic clk     = 1'b0;
    logic rst_a_n = 1'b0;
    logic rst_b_n = 1'b0;
    int   e_a = 0;
    int   e_b = 0;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    vga_sync_gen_if bus_a ();
    vga_sync_gen_if bus_b ();

    vga_sync_gen #(
        .CLK_DIV(A_CD), .H_VISIBLE(A_HV), .H_FRONT(A_HF), .H_SYNC(A_HS), .H_BACK(A_HB),
        .V_VISIBLE(A_VV), .V_FRONT(A_VF), .V_SYNC(A_VS), .V_BACK(A_VB)
    ) dut_a (
        .clk   (clk),
        .rst_n (rst_a_n),
        .vga   (bus_a)
    );

    vga_sync_gen #(
        .CLK_DIV(B_CD), .H_VISIBLE(B_HV), .H_FRONT(B_HF), .H_SYNC(B_HS), .H_BACK(B_HB),
        .V_VISIBLE(B_VV), .V_FRONT(B_VF), .V_SYNC(B_VS), .V_BACK(B_VB),
        .FRAME_RST(B_FC0)
    ) dut_b (
        .clk   (clk),
        .rst_n (rst_b_n),
        .vga   (bus_b)
    );

    // Clock edges seen since each reset was last released
    always @(posedge clk or negedge rst_a_n) begin
        if (!rst_a_n) e_a <= 0;
        else          e_a <= e_a + 1;
    end

    always @(posedge clk or negedge rst_b_n) begin
        if (!rst_b_n) e_b <= 0;
        else          e_b <= e_b + 1;
    end

    // Position after e edges: e/cd pixel steps from (0,0), wrapped by frame size
    function automatic obs_t model(int e, int cd, int hv, int hf, int hs, int hb,
                                   int vv, int vf, int vs, int vb, int fc0);
        obs_t m;
        int ht, vt, tot, a, pos, frames, hc, vc;
        ht  = hv + hf + hs + hb;
        vt  = vv + vf + vs + vb;
        tot = ht * vt;
        a   = e / cd;
        pos = a % tot;
        hc  = pos % ht;
        vc  = pos / ht;
        m.hc  = 10'(hc);
        m.vc  = 10'(vc);
        m.pix = (e > 0) && (e % cd == 0);
        m.rf  = m.pix && (pos == vv * ht);
        frames = (a >= vv * ht) ? ((a - vv * ht) / tot + 1) : 0;
        m.fc  = 16'((fc0 + frames) % 65536);
        m.hs  = !((hc >= hv + hf) && (hc < hv + hf + hs));
        m.vs  = !((vc >= vv + vf) && (vc < vv + vf + vs));
        m.von = (hc < hv) && (vc < vv);
        return m;
    endfunction

    function automatic obs_t model_a(int e);
        return model(e, A_CD, A_HV, A_HF, A_HS, A_HB, A_VV, A_VF, A_VS, A_VB, 0);
    endfunction

    function automatic obs_t model_b(int e);
        return model(e, B_CD, B_HV, B_HF, B_HS, B_HB, B_VV, B_VF, B_VS, B_VB, int'(B_FC0));
    endfunction

    function automatic obs_t obs_a();
        obs_t o;
        o.hc = bus_a.hc; o.vc = bus_a.vc; o.pix = bus_a.pix_tick; o.von = bus_a.video_on;
        o.hs = bus_a.hsync; o.vs = bus_a.vsync; o.rf = bus_a.ref_tick; o.fc = bus_a.frame_cnt;
        return o;
    endfunction

    function automatic obs_t obs_b();
        obs_t o;
        o.hc = bus_b.hc; o.vc = bus_b.vc; o.pix = bus_b.pix_tick; o.von = bus_b.video_on;
        o.hs = bus_b.hsync; o.vs = bus_b.vsync; o.rf = bus_b.ref_tick; o.fc = bus_b.frame_cnt;
        return o;
    endfunction

    function automatic vec_t mk(int n, int hc, int vc, bit pix, bit von, bit hs,
                                bit vs, bit rf, int fc);
        vec_t v;
        v.n_edge = n;
        v.exp    = '{hc: 10'(hc), vc: 10'(vc), pix: pix, von: von, hs: hs,
                     vs: vs, rf: rf, fc: 16'(fc)};
        return v;
    endfunction

    task automatic check(input string name, input obs_t act, input obs_t exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got hc=%0d vc=%0d pix=%b von=%b hs=%b vs=%b ref=%b fc=%0d | want hc=%0d vc=%0d pix=%b von=%b hs=%b vs=%b ref=%b fc=%0d",
                     name, act.hc, act.vc, act.pix, act.von, act.hs, act.vs, act.rf, act.fc,
                     exp.hc, exp.vc, exp.pix, exp.von, exp.hs, exp.vs, exp.rf, exp.fc);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d want %0d", name, act, exp);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: run did not finish (errors=%0d checks=%0d)", errors, checks);
        $fatal(1, "watchdog expired");
    end

    initial begin
        vec_t tbl[$];
        obs_t rst_a_exp;
        obs_t rst_b_exp;
        obs_t m;
        int   guard;
        int   cnt;
        int   d;
        int   hold;
        int   pix_cnt;
        int   ref_e[$];
        int   ref_fc[$];

        rst_a_exp = '{hc: 10'd0, vc: 10'd0, pix: 1'b0, von: 1'b1, hs: 1'b1,
                      vs: 1'b1, rf: 1'b0, fc: 16'd0};
        rst_b_exp    = rst_a_exp;
        rst_b_exp.fc = B_FC0;

        // Instance A: 16 px/line (hsync low 10..12), 9 lines (vsync low 5..6), 4 clks/px
        tbl.push_back(mk(  0,  0, 0, 0, 1, 1, 1, 0, 0));
        tbl.push_back(mk(  3,  0, 0, 0, 1, 1, 1, 0, 0));
        tbl.push_back(mk(  4,  1, 0, 1, 1, 1, 1, 0, 0));
        tbl.push_back(mk(  5,  1, 0, 0, 1, 1, 1, 0, 0));
        tbl.push_back(mk( 28,  7, 0, 1, 1, 1, 1, 0, 0));
        tbl.push_back(mk( 32,  8, 0, 1, 0, 1, 1, 0, 0));
        tbl.push_back(mk( 39,  9, 0, 0, 0, 1, 1, 0, 0));
        tbl.push_back(mk( 40, 10, 0, 1, 0, 0, 1, 0, 0));
        tbl.push_back(mk( 51, 12, 0, 0, 0, 0, 1, 0, 0));
        tbl.push_back(mk( 52, 13, 0, 1, 0, 1, 1, 0, 0));
        tbl.push_back(mk( 60, 15, 0, 1, 0, 1, 1, 0, 0));
        tbl.push_back(mk( 64,  0, 1, 1, 1, 1, 1, 0, 0));
        tbl.push_back(mk(256,  0, 4, 1, 0, 1, 1, 1, 1));
        tbl.push_back(mk(257,  0, 4, 0, 0, 1, 1, 0, 1));
        tbl.push_back(mk(320,  0, 5, 1, 0, 1, 0, 0, 1));
        tbl.push_back(mk(447, 15, 6, 0, 0, 1, 0, 0, 1));
        tbl.push_back(mk(448,  0, 7, 1, 0, 1, 1, 0, 1));
        tbl.push_back(mk(572, 15, 8, 1, 0, 1, 1, 0, 1));
        tbl.push_back(mk(576,  0, 0, 1, 1, 1, 1, 0, 1));
        tbl.push_back(mk(832,  0, 4, 1, 0, 1, 1, 1, 2));

        repeat (3) @(negedge clk);
        check("reset_a", obs_a(), rst_a_exp);
        check("reset_b", obs_b(), rst_b_exp);

        // Table-driven walk through line and frame boundaries
        rst_a_n = 1'b1;
        foreach (tbl[i]) begin
            guard = 0;
            while ((e_a < tbl[i].n_edge) && (guard < 4000)) begin
                @(negedge clk);
                guard++;
            end
            check($sformatf("vec%0d_edge%0d", i, tbl[i].n_edge), obs_a(), tbl[i].exp);
        end

        // ref_tick is one clk wide and repeats every 16*9*4 clks
        @(negedge clk);
        check_int("ref_one_clk_wide", int'(bus_a.ref_tick), 0);
        cnt = 1;
        while ((bus_a.ref_tick !== 1'b1) && (cnt < 2000)) begin
            @(negedge clk);
            cnt++;
        end
        check_int("ref_period_a", cnt, 576);

        // Asynchronous reset in the middle of a frame at position (10,2)
        guard = 0;
        m = model_a(e_a);
        while (!((m.hc == 10'd10) && (m.vc == 10'd2)) && (guard < 2000)) begin
            @(negedge clk);
            guard++;
            m = model_a(e_a);
        end
        check("pre_reset_pos", obs_a(), m);
        #2 rst_a_n = 1'b0;
        #1 check("async_reset_immediate", obs_a(), rst_a_exp);
        @(negedge clk);
        check("reset_held", obs_a(), rst_a_exp);
        rst_a_n = 1'b1;
        cnt = 0;
        while ((bus_a.ref_tick !== 1'b1) && (cnt < 2000)) begin
            @(negedge clk);
            cnt++;
        end
        check_int("first_ref_after_reset_edges", cnt, A_VV * 16 * A_CD);
        check_int("frame_cnt_after_reset", int'(bus_a.frame_cnt), 1);

        // Random run lengths and random asynchronous reset points, every cycle modelled
        for (int r = 0; r < 8; r++) begin
            repeat ($urandom_range(20, 900)) begin
                @(negedge clk);
                check("rand_a", obs_a(), model_a(e_a));
            end
            d = $urandom_range(1, 3);
            #(d) rst_a_n = 1'b0;
            #1 check("rand_async_reset", obs_a(), rst_a_exp);
            @(negedge clk);
            hold = $urandom_range(0, 3);
            repeat (hold) @(negedge clk);
            rst_a_n = 1'b1;
        end

        // Instance B: CLK_DIV=1, frame counter crosses 65535 -> 0
        rst_b_n = 1'b1;
        pix_cnt = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            check("div1", obs_b(), model_b(e_b));
            if (bus_b.pix_tick === 1'b1) pix_cnt++;
            if (bus_b.ref_tick === 1'b1) begin
                ref_e.push_back(e_b);
                ref_fc.push_back(int'(bus_b.frame_cnt));
            end
        end
        check_int("div1_pix_constant", pix_cnt, 200);
        check_int("div1_ref_count", ref_e.size(), 5);
        if (ref_e.size() >= 3) begin
            check_int("div1_ref_period", ref_e[1] - ref_e[0], 42);
            check_int("div1_first_ref_edge", ref_e[0], 21);
            check_int("fc_before_wrap", ref_fc[1], 65535);
            check_int("fc_wrap_to_zero", ref_fc[2], 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
